imm_ext_pipe: RTL and testbench

Parametrised, pipelined immediate-extension stage for the processor datapath. Takes a raw instruction immediate plus a mode selector, sign- or zero-extends (and optionally shifts) it to the datapath width, and delivers the result one cycle later over a valid/ready handshake. A one-entry skid buffer decouples decode from the operand-fetch stage, so `in_ready` is fully registered and throughput stays at one immediate per cycle.

---
 rtl/imm_ext_pkg.sv | 18 +
 rtl/imm_ext_core.sv | 44 ++++
 rtl/imm_ext_pipe.sv | 102 ++++++++++
 tb/tb_imm_ext_pipe.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared mode encoding and default widths for the immediate-extension stage.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        IMM_SEXT_FULL    = 3'b000,
        IMM_SEXT_MID     = 3'b001,
        IMM_SEXT_SHORT   = 3'b010,
        IMM_ZEXT_FULL    = 3'b011,
        IMM_SEXT_MID_SH1 = 3'b100,
        IMM_LOAD_HIGH    = 3'b101
    } imm_sel_e;

    localparam int IMM_OUT_W_DEF   = 16;
    localparam int IMM_IMM_W_DEF   = 9;
    localparam int IMM_MID_W_DEF   = 8;
    localparam int IMM_SHORT_W_DEF = 5;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational mode decode and extension of a raw immediate.
// IMM_EXT_SHIFT_EN enables the branch-offset and load-high modes.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int OUT_W   = IMM_OUT_W_DEF,
    parameter int IMM_W   = IMM_IMM_W_DEF,
    parameter int MID_W   = IMM_MID_W_DEF,
    parameter int SHORT_W = IMM_SHORT_W_DEF
) (
    input  logic [IMM_W-1:0] imm_i,
    input  logic [2:0]       sel_i,
    output logic [OUT_W-1:0] data_o,
    output logic             err_o
);

    logic [OUT_W-1:0] sext_full;
    logic [OUT_W-1:0] sext_mid;
    logic [OUT_W-1:0] sext_short;
    logic [OUT_W-1:0] zext_full;

    assign sext_full  = {{(OUT_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
    assign sext_mid   = {{(OUT_W-MID_W){imm_i[MID_W-1]}}, imm_i[MID_W-1:0]};
    assign sext_short = {{(OUT_W-SHORT_W){imm_i[SHORT_W-1]}}, imm_i[SHORT_W-1:0]};
    assign zext_full  = {{(OUT_W-IMM_W){1'b0}}, imm_i};

    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        case (sel_i)
            IMM_SEXT_FULL:    data_o = sext_full;
            IMM_SEXT_MID:     data_o = sext_mid;
            IMM_SEXT_SHORT:   data_o = sext_short;
            IMM_ZEXT_FULL:    data_o = zext_full;
`ifdef IMM_EXT_SHIFT_EN
            // The MSB shifted out is simply lost; no overflow reporting.
            IMM_SEXT_MID_SH1: data_o = {sext_mid[OUT_W-2:0], 1'b0};
            IMM_LOAD_HIGH:    data_o[15:8] = imm_i[7:0];
`endif
            default:          err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a one-entry skid buffer so that
// in_ready comes straight from a flop. IMM_EXT_SHIFT_EN gates the shift modes.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int OUT_W   = IMM_OUT_W_DEF,
    parameter int IMM_W   = IMM_IMM_W_DEF,
    parameter int MID_W   = IMM_MID_W_DEF,
    parameter int SHORT_W = IMM_SHORT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [2:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    logic             r_vld_q, r_vld_d;
    logic [OUT_W-1:0] r_data_q, r_data_d;
    logic             r_err_q, r_err_d;
    logic             s_vld_q, s_vld_d;
    logic [OUT_W-1:0] s_data_q, s_data_d;
    logic             s_err_q, s_err_d;

    logic             accept;
    logic             r_free;

    imm_ext_core #(
        .OUT_W  (OUT_W),
        .IMM_W  (IMM_W),
        .MID_W  (MID_W),
        .SHORT_W(SHORT_W)
    ) u_core (
        .imm_i (in_imm),
        .sel_i (in_sel),
        .data_o(ext_data),
        .err_o (ext_err)
    );

    assign in_ready = !s_vld_q && !rst;
    assign accept   = in_valid && in_ready;
    // R can take a new beat when it is empty or its current beat leaves now.
    assign r_free   = !r_vld_q || out_ready;

    always_comb begin
        r_vld_d  = r_vld_q;
        r_data_d = r_data_q;
        r_err_d  = r_err_q;
        s_vld_d  = s_vld_q;
        s_data_d = s_data_q;
        s_err_d  = s_err_q;
        if (r_free) begin
            if (s_vld_q) begin
                r_vld_d  = 1'b1;
                r_data_d = s_data_q;
                r_err_d  = s_err_q;
                s_vld_d  = 1'b0;
            end else if (accept) begin
                r_vld_d  = 1'b1;
                r_data_d = ext_data;
                r_err_d  = ext_err;
            end else begin
                r_vld_d  = 1'b0;
            end
        end else if (accept) begin
            s_vld_d  = 1'b1;
            s_data_d = ext_data;
            s_err_d  = ext_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_q  <= 1'b0;
            r_data_q <= '0;
            r_err_q  <= 1'b0;
            s_vld_q  <= 1'b0;
            s_data_q <= '0;
            s_err_q  <= 1'b0;
        end else begin
            r_vld_q  <= r_vld_d;
            r_data_q <= r_data_d;
            r_err_q  <= r_err_d;
            s_vld_q  <= s_vld_d;
            s_data_q <= s_data_d;
            s_err_q  <= s_err_d;
        end
    end

    assign out_valid = r_vld_q;
    assign out_data  = r_data_q;
    assign out_err   = r_err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Randomized and directed bench for imm_ext_pipe against a queue-based model.
module tb_imm_ext_pipe;

`ifdef IMM_EXT_SHIFT_EN
    localparam bit SH_EN = 1'b1;
`else
    localparam bit SH_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_imm;
    logic [2:0]  in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_err;

    int total = 0;
    int bad   = 0;
    logic [16:0] exp_q[$];
    logic        was_rst = 1'b0;

    always #5 clk = ~clk;

    imm_ext_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_imm   (in_imm),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_err  (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: {err, data} from the mode rules using signed integer arithmetic.
    function automatic logic [16:0] ref_ext(input int imm, input int sel);
        int v;
        int b;
        logic err;
        err = 1'b0;
        v   = 0;
        case (sel)
            0: v = (imm >= 256) ? imm - 512 : imm;
            1: begin b = imm % 256; v = (b >= 128) ? b - 256 : b; end
            2: begin b = imm % 32;  v = (b >= 16)  ? b - 32  : b; end
            3: v = imm;
            4: if (SH_EN) begin b = imm % 256; v = ((b >= 128) ? b - 256 : b) * 2; end
               else err = 1'b1;
            5: if (SH_EN) v = (imm % 256) * 256;
               else err = 1'b1;
            default: err = 1'b1;
        endcase
        return {err, 16'(v)};
    endfunction

    // One clock: drive inputs, check and update the model mid-cycle, advance.
    task automatic cyc(input logic r, input logic v, input logic [8:0] imm,
                       input logic [2:0] sel, input logic ordy);
        logic [16:0] e;
        rst = r; in_valid = v; in_imm = imm; in_sel = sel; out_ready = ordy;
        @(negedge clk);
        chk("in_ready", in_ready, (!rst && exp_q.size() < 2));
        chk("out_valid", out_valid, exp_q.size() > 0);
        if (was_rst) begin
            chk("rst_data", out_data, 0);
            chk("rst_err", out_err, 0);
        end
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e[15:0]);
                chk("out_err", out_err, e[16]);
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_ext(int'(in_imm), int'(in_sel)));
        end
        was_rst = rst;
        @(posedge clk);
        #1;
    endtask

    // Send one beat into an idle pipe and check the literal result a cycle later.
    task automatic dconst(input logic [8:0] imm, input logic [2:0] sel,
                          input logic [15:0] ed, input logic ee);
        cyc(1'b0, 1'b1, imm, sel, 1'b1);
        #3;
        chk("const_vld", out_valid, 1);
        chk("const_data", out_data, ed);
        chk("const_err", out_err, ee);
        cyc(1'b0, 1'b0, 9'h0, 3'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_sel = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 9'h0, 3'h0, 1'b0);
        cyc(1'b1, 1'b0, 9'h0, 3'h0, 1'b0);
        cyc(1'b0, 1'b0, 9'h0, 3'h0, 1'b1);

        // Basic and shifted modes against literal results.
        dconst(9'h100, 3'b000, 16'hFF00, 1'b0);
        dconst(9'h010, 3'b010, 16'hFFF0, 1'b0);
        dconst(9'h1FF, 3'b011, 16'h01FF, 1'b0);
        dconst(9'h0FF, 3'b001, 16'hFFFF, 1'b0);
        if (SH_EN) begin
            dconst(9'h0FF, 3'b100, 16'hFFFE, 1'b0);
            dconst(9'h012, 3'b101, 16'h1200, 1'b0);
        end else begin
            dconst(9'h0FF, 3'b100, 16'h0000, 1'b1);
            dconst(9'h012, 3'b101, 16'h0000, 1'b1);
        end
        dconst(9'h1AB, 3'b110, 16'h0000, 1'b1);
        dconst(9'h1AB, 3'b111, 16'h0000, 1'b1);

        // Backpressure: A, B, C offered while the consumer stalls.
        cyc(1'b0, 1'b1, 9'h0A1, 3'b000, 1'b0);
        cyc(1'b0, 1'b1, 9'h0B2, 3'b001, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 9'h1C3, 3'b011, 1'b0);
        cyc(1'b0, 1'b1, 9'h1C3, 3'b011, 1'b1);
        cyc(1'b0, 1'b0, 9'h0, 3'h0, 1'b1);
        cyc(1'b0, 1'b0, 9'h0, 3'h0, 1'b1);
        cyc(1'b0, 1'b0, 9'h0, 3'h0, 1'b1);
        chk("bp_drain", exp_q.size(), 0);

        // Streaming at full rate.
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 1'b1, 9'($urandom), 3'($urandom_range(0, 5)), 1'b1);
        cyc(1'b0, 1'b0, 9'h0, 3'h0, 1'b1);

        // Reset with both R and S full.
        cyc(1'b0, 1'b1, 9'h055, 3'b000, 1'b0);
        cyc(1'b0, 1'b1, 9'h066, 3'b000, 1'b0);
        cyc(1'b1, 1'b1, 9'h077, 3'b000, 1'b0);
        cyc(1'b0, 1'b0, 9'h0, 3'h0, 1'b1);

        // Random traffic, including occasional resets.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                9'($urandom), 3'($urandom), ($urandom_range(0, 2) != 0));
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 9'h0, 3'h0, 1'b1);
        chk("final_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
